// File: rtl/systolic_cfg_pkg.sv
// systolic_cfg_pkg: register map, STATUS bit indices, FSM state and the 16-bit dim/address type shared with the array top
package systolic_cfg_pkg;
  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_STATUS   = 1;
  localparam int ADDR_M        = 2;
  localparam int ADDR_N        = 3;
  localparam int ADDR_P        = 4;
  localparam int ADDR_BASE_A   = 5;
  localparam int ADDR_BASE_B   = 6;
  localparam int ADDR_BASE_C   = 7;
  localparam int ADDR_CYCLES   = 8;
  localparam int ADDR_IRQ_MASK = 9;
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_ERR_DIM  = 2;
  localparam int STAT_ERR_BUSY = 3;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef logic [15:0] dim_t;
  function automatic logic dim_legal(dim_t d, int unsigned max_dim);
    return d != '0 && {16'd0, d} <= max_dim;
  endfunction
endpackage

// File: rtl/systolic_cfg_regfile.sv
// systolic_cfg_regfile: software regs M..BASE_C, sticky W1C STATUS (set wins), registered read mux; SYSTOLIC_CFG_IRQ_EN adds irq_mask reg and irq port
module systolic_cfg_regfile
  import systolic_cfg_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          busy,
  input  logic [DW-1:0] cycles,
  input  logic          set_done,
  input  logic          clr_done,
  input  logic          set_err_dim,
  input  logic          set_err_busy,
  output dim_t          m,
  output dim_t          n,
  output dim_t          p,
  output dim_t          base_a,
  output dim_t          base_b,
  output dim_t          base_c,
  output logic          done,
  output logic          rvalid,
`ifdef SYSTOLIC_CFG_IRQ_EN
  output logic          irq,
`endif
  output logic [DW-1:0] rdata
);
  logic [31:0] a;
  logic [3:0] w1c;
  logic err_dim, err_busy, unused_bits;
  logic [DW-1:0] rmux;
  assign a = 32'(addr);
  assign w1c = wr_en && a == ADDR_STATUS ? wdata[3:0] : 4'h0;
  assign unused_bits = ^wdata[DW-1:16];
`ifdef SYSTOLIC_CFG_IRQ_EN
  logic [1:0] irq_mask;
  assign irq = (done & irq_mask[0]) | ((err_dim | err_busy) & irq_mask[1]);
`endif
  always_comb begin
    rmux = '0;
    case (a)
      ADDR_STATUS: rmux = DW'({err_busy, err_dim, done, busy});
      ADDR_M:      rmux = DW'(m);
      ADDR_N:      rmux = DW'(n);
      ADDR_P:      rmux = DW'(p);
      ADDR_BASE_A: rmux = DW'(base_a);
      ADDR_BASE_B: rmux = DW'(base_b);
      ADDR_BASE_C: rmux = DW'(base_c);
      ADDR_CYCLES: rmux = cycles;
`ifdef SYSTOLIC_CFG_IRQ_EN
      ADDR_IRQ_MASK: rmux = DW'(irq_mask);
`endif
      default:     rmux = '0;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      {m, n, p, base_a, base_b, base_c} <= '0;
      {done, err_dim, err_busy, rvalid} <= '0;
      rdata <= '0;
`ifdef SYSTOLIC_CFG_IRQ_EN
      irq_mask <= '0;
`endif
    end else begin
      if (wr_en)
        case (a)
          ADDR_M:      m <= dim_t'(wdata);
          ADDR_N:      n <= dim_t'(wdata);
          ADDR_P:      p <= dim_t'(wdata);
          ADDR_BASE_A: base_a <= dim_t'(wdata);
          ADDR_BASE_B: base_b <= dim_t'(wdata);
          ADDR_BASE_C: base_c <= dim_t'(wdata);
`ifdef SYSTOLIC_CFG_IRQ_EN
          ADDR_IRQ_MASK: irq_mask <= wdata[1:0];
`endif
          default: ;
        endcase
      done <= set_done | (done & ~w1c[STAT_DONE] & ~clr_done);
      err_dim <= set_err_dim | (err_dim & ~w1c[STAT_ERR_DIM]);
      err_busy <= set_err_busy | (err_busy & ~w1c[STAT_ERR_BUSY]);
      rvalid <= rd_en;
      rdata <= rd_en ? rmux : '0;
    end
endmodule

// File: rtl/systolic_array_config.sv
// systolic_array_config: cfg register port, dim check, one-cycle start pulse, frozen dims/bases, done-edge FSM, busy counter; SYSTOLIC_CFG_IRQ_EN adds irq_o
module systolic_array_config
  import systolic_cfg_pkg::*;
#(
  parameter int          CFG_ADDR_WIDTH  = 4,
  parameter int          CFG_DATA_WIDTH  = 32,
  parameter int unsigned MAX_DIM         = 1024,
  parameter int          CYCLE_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_write_i,
  input  logic [CFG_ADDR_WIDTH-1:0] cfg_addr_i,
  input  logic [CFG_DATA_WIDTH-1:0] cfg_wdata_i,
  output logic                      cfg_ready_o,
  output logic                      cfg_rvalid_o,
  output logic [CFG_DATA_WIDTH-1:0] cfg_rdata_o,
  output logic                      start_o,
  output dim_t                      m_o,
  output dim_t                      n_o,
  output dim_t                      p_o,
  output dim_t                      base_addr_a_o,
  output dim_t                      base_addr_b_o,
  output dim_t                      base_addr_c_o,
  input  logic                      operation_done_i,
`ifdef SYSTOLIC_CFG_IRQ_EN
  output logic                      irq_o,
`endif
  output logic                      busy_o
);
  state_t state;
  logic wr, rd, done_q, done_edge, drop, start_req, dims_ok, go;
  logic [31:0] a;
  logic [CYCLE_CNT_WIDTH-1:0] cycles;
  dim_t reg_m, reg_n, reg_p, reg_a, reg_b, reg_c;
  assign wr = cfg_valid_i & cfg_write_i;
  assign rd = cfg_valid_i & ~cfg_write_i;
  assign a = 32'(cfg_addr_i);
  assign done_edge = state == BUSY && operation_done_i && !done_q;
  assign drop = state == BUSY && wr && (a == ADDR_CTRL || (a >= ADDR_M && a <= ADDR_BASE_C));
  assign start_req = state == IDLE && wr && a == ADDR_CTRL && cfg_wdata_i[0];
  assign dims_ok = dim_legal(reg_m, MAX_DIM) && dim_legal(reg_n, MAX_DIM) && dim_legal(reg_p, MAX_DIM);
  assign go = start_req && dims_ok;
  assign cfg_ready_o = 1'b1;
  assign busy_o = state == BUSY;
  systolic_cfg_regfile #(.AW(CFG_ADDR_WIDTH), .DW(CFG_DATA_WIDTH)) u_regfile (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr && !drop),
    .rd_en        (rd),
    .addr         (cfg_addr_i),
    .wdata        (cfg_wdata_i),
    .busy         (busy_o),
    .cycles       (CFG_DATA_WIDTH'(cycles)),
    .set_done     (done_edge),
    .clr_done     (go),
    .set_err_dim  (start_req && !dims_ok),
    .set_err_busy (drop),
    .m            (reg_m),
    .n            (reg_n),
    .p            (reg_p),
    .base_a       (reg_a),
    .base_b       (reg_b),
    .base_c       (reg_c),
    .done         (),
    .rvalid       (cfg_rvalid_o),
`ifdef SYSTOLIC_CFG_IRQ_EN
    .irq          (irq_o),
`endif
    .rdata        (cfg_rdata_o)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      {start_o, done_q} <= '0;
      cycles <= '0;
      {m_o, n_o, p_o, base_addr_a_o, base_addr_b_o, base_addr_c_o} <= '0;
    end else begin
      done_q <= operation_done_i;
      start_o <= go;
      if (go) begin
        state <= BUSY;
        cycles <= '0;
        {m_o, n_o, p_o, base_addr_a_o, base_addr_b_o, base_addr_c_o} <= {reg_m, reg_n, reg_p, reg_a, reg_b, reg_c};
      end else if (state == BUSY) begin
        cycles <= &cycles ? cycles : cycles + CYCLE_CNT_WIDTH'(1);
        if (done_edge) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_systolic_array_config.sv
// tb_systolic_array_config: directed test-plan sequence plus random register traffic, checked every cycle against a register-map model
module tb_systolic_array_config;
  logic clk = 0, reset = 1, cfg_valid_i = 0, cfg_write_i = 0, operation_done_i = 0;
  logic [3:0] cfg_addr_i = 0;
  logic [31:0] cfg_wdata_i = 0;
  logic cfg_ready_o, cfg_rvalid_o, start_o, busy_o;
  logic [31:0] cfg_rdata_o;
  logic [15:0] m_o, n_o, p_o, base_addr_a_o, base_addr_b_o, base_addr_c_o;
`ifdef SYSTOLIC_CFG_IRQ_EN
  logic irq_o;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  systolic_array_config dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_valid_i      (cfg_valid_i),
    .cfg_write_i      (cfg_write_i),
    .cfg_addr_i       (cfg_addr_i),
    .cfg_wdata_i      (cfg_wdata_i),
    .cfg_ready_o      (cfg_ready_o),
    .cfg_rvalid_o     (cfg_rvalid_o),
    .cfg_rdata_o      (cfg_rdata_o),
    .start_o          (start_o),
    .m_o              (m_o),
    .n_o              (n_o),
    .p_o              (p_o),
    .base_addr_a_o    (base_addr_a_o),
    .base_addr_b_o    (base_addr_b_o),
    .base_addr_c_o    (base_addr_c_o),
    .operation_done_i (operation_done_i),
`ifdef SYSTOLIC_CFG_IRQ_EN
    .irq_o            (irq_o),
`endif
    .busy_o           (busy_o)
  );
  logic [15:0] r [0:15];
  logic [15:0] sh [0:15];
  logic mb, md, med, meb, mstart, mprev, mrv;
  logic [1:0] mmask;
  logic [31:0] mcyc, mrd;
  bit started = 0;
  function automatic logic legal(logic [15:0] d);
    return d >= 16'd1 && d <= 16'd1024;
  endfunction
  function automatic logic [31:0] model_read(int a);
    case (a)
      1: return {28'd0, meb, med, md, mb};
      2, 3, 4, 5, 6, 7: return {16'd0, r[a]};
      8: return mcyc;
`ifdef SYSTOLIC_CFG_IRQ_EN
      9: return {30'd0, mmask};
`endif
      default: return 32'd0;
    endcase
  endfunction
  always @(posedge clk) begin
    logic wr, rd, done_edge, drop, hit_start, dims_ok;
    logic [3:0] w1c;
    int a;
    a = int'(cfg_addr_i);
    wr = cfg_valid_i && cfg_write_i;
    rd = cfg_valid_i && !cfg_write_i;
    if (reset) begin
      {mb, md, med, meb, mstart, mprev, mrv} = '0;
      mmask = '0;
      mcyc = '0;
      mrd = '0;
      for (int i = 0; i < 16; i++) begin
        r[i] = '0;
        sh[i] = '0;
      end
    end else begin
      mrv = rd;
      mrd = rd ? model_read(a) : 32'd0;
      done_edge = mb && operation_done_i && !mprev;
      drop = mb && wr && (a == 0 || (a >= 2 && a <= 7));
      hit_start = !mb && wr && a == 0 && cfg_wdata_i[0];
      dims_ok = legal(r[2]) && legal(r[3]) && legal(r[4]);
      w1c = (wr && a == 1) ? cfg_wdata_i[3:0] : 4'h0;
      md = done_edge || (md && !w1c[1] && !(hit_start && dims_ok));
      med = (hit_start && !dims_ok) || (med && !w1c[2]);
      meb = drop || (meb && !w1c[3]);
      if (wr && !drop && a >= 2 && a <= 7) r[a] = cfg_wdata_i[15:0];
`ifdef SYSTOLIC_CFG_IRQ_EN
      if (wr && a == 9) mmask = cfg_wdata_i[1:0];
`endif
      mstart = hit_start && dims_ok;
      if (mstart) begin
        mcyc = '0;
        for (int i = 2; i < 8; i++) sh[i] = r[i];
      end else if (mb && mcyc != '1) mcyc++;
      mb = mstart || (mb && !done_edge);
      mprev = operation_done_i;
    end
    started = 1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (started) begin
    chk("start_o", 32'(start_o), 32'(mstart));
    chk("busy_o", 32'(busy_o), 32'(mb));
    chk("m_o", 32'(m_o), 32'(sh[2]));
    chk("n_o", 32'(n_o), 32'(sh[3]));
    chk("p_o", 32'(p_o), 32'(sh[4]));
    chk("base_a", 32'(base_addr_a_o), 32'(sh[5]));
    chk("base_b", 32'(base_addr_b_o), 32'(sh[6]));
    chk("base_c", 32'(base_addr_c_o), 32'(sh[7]));
    chk("ready", 32'(cfg_ready_o), 32'd1);
    chk("rvalid", 32'(cfg_rvalid_o), 32'(mrv));
    chk("rdata", cfg_rdata_o, mrd);
`ifdef SYSTOLIC_CFG_IRQ_EN
    chk("irq_o", 32'(irq_o), 32'((md & mmask[0]) | ((med | meb) & mmask[1])));
`endif
  end
  task automatic wr(input int a, input logic [31:0] d);
    cfg_valid_i = 1;
    cfg_write_i = 1;
    cfg_addr_i = 4'(a);
    cfg_wdata_i = d;
    @(posedge clk);
    #1;
    cfg_valid_i = 0;
    cfg_write_i = 0;
  endtask
  task automatic rchk(input string nm, input int a, input logic [31:0] exp);
    cfg_valid_i = 1;
    cfg_write_i = 0;
    cfg_addr_i = 4'(a);
    @(posedge clk);
    #1;
    cfg_valid_i = 0;
    chk(nm, cfg_rdata_o, exp);
  endtask
  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  initial begin
    idle(3);
    reset = 0;
    rchk("rst_status", 1, 32'h0);
    rchk("rst_cycles", 8, 32'd0);
    wr(2, 4); wr(3, 8); wr(4, 32); wr(5, 'h100); wr(6, 'h200); wr(7, 'h400); wr(0, 1);
    chk("t1_start", 32'(start_o), 1);
    chk("t1_m", 32'(m_o), 4);
    chk("t1_p", 32'(p_o), 32);
    chk("t1_base_c", 32'(base_addr_c_o), 'h400);
    chk("t1_busy", 32'(busy_o), 1);
    idle(1);
    chk("t1_pulse_len", 32'(start_o), 0);
    idle(48);
    operation_done_i = 1;
    idle(1);
    chk("t1_idle", 32'(busy_o), 0);
    operation_done_i = 0;
    rchk("t1_status", 1, 32'h2);
    rchk("t1_cycles", 8, 32'd50);
    wr(1, 2);
    wr(3, 0);
    wr(0, 1);
    chk("t2_no_start", 32'(start_o), 0);
    chk("t2_no_busy", 32'(busy_o), 0);
    rchk("t2_status", 1, 32'h4);
    wr(1, 4);
    rchk("t2_w1c", 1, 32'h0);
    wr(3, 8);
    wr(0, 1);
    wr(2, 9);
    wr(0, 1);
    chk("t3_no_pulse", 32'(start_o), 0);
    chk("t3_m_frozen", 32'(m_o), 4);
    rchk("t3_status", 1, 32'h9);
    operation_done_i = 1;
    idle(1);
    operation_done_i = 0;
    chk("t3_idle", 32'(busy_o), 0);
    rchk("t3_m_reg", 2, 32'd4);
    wr(1, 'hF);
    operation_done_i = 1;
    idle(2);
    wr(0, 1);
    chk("t4_start", 32'(start_o), 1);
    idle(5);
    chk("t4_no_early_exit", 32'(busy_o), 1);
    operation_done_i = 0;
    idle(10);
    operation_done_i = 1;
    idle(1);
    chk("t4_exit", 32'(busy_o), 0);
    rchk("t4_status", 1, 32'h2);
    operation_done_i = 0;
    wr(0, 1);
    chk("t5_start", 32'(start_o), 1);
    idle(3);
    reset = 1;
    idle(1);
    chk("t5_rst_busy", 32'(busy_o), 0);
    chk("t5_rst_m", 32'(m_o), 0);
    chk("t5_rst_base_a", 32'(base_addr_a_o), 0);
    reset = 0;
    rchk("t5_status", 1, 32'h0);
    rchk("t5_cycles", 8, 32'd0);
    rchk("t5_m_reg", 2, 32'd0);
    wr(2, 2); wr(3, 3); wr(4, 5); wr(0, 1);
    chk("t5_restart", 32'(start_o), 1);
    chk("t5_m", 32'(m_o), 2);
    chk("t5_n", 32'(n_o), 3);
    chk("t5_p", 32'(p_o), 5);
    idle(3);
`ifdef SYSTOLIC_CFG_IRQ_EN
    wr(9, 1);
`endif
    operation_done_i = 1;
    idle(1);
    operation_done_i = 0;
    chk("t5_done", 32'(busy_o), 0);
`ifdef SYSTOLIC_CFG_IRQ_EN
    chk("t6_irq_set", 32'(irq_o), 1);
    wr(1, 2);
    chk("t6_irq_clr", 32'(irq_o), 0);
`else
    wr(9, 3);
    rchk("t6_mask_absent", 9, 32'h0);
`endif
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 599) == 0;
      cfg_valid_i = $urandom_range(0, 1) == 1;
      cfg_write_i = $urandom_range(0, 2) != 0;
      cfg_addr_i = 4'($urandom_range(0, 10));
      cfg_wdata_i = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 1100);
      if ($urandom_range(0, 11) == 0) operation_done_i = ~operation_done_i;
      idle(1);
    end
    {reset, cfg_valid_i, cfg_write_i, operation_done_i} = '0;
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
